// File: rtl/energy_arith_pkg.sv
// rtl/energy_arith_pkg.sv - shared encodings and defaults for the energy-supervision arithmetic units
package energy_arith_pkg;

   // Default operand width shared by the sequential multiplier and divider
   localparam int DEFAULT_WIDTH = 32;

   // Two-state sequencer: waiting for go, or iterating over operand bits
   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/multiplication32_if.sv
// rtl/multiplication32_if.sv - go/done request bus between a requester and the sequential multiplier
interface multiplication32_if #(
   parameter int WIDTH = energy_arith_pkg::DEFAULT_WIDTH
) ();
   import energy_arith_pkg::*;

   logic                 go;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   // Requester side: issues operands and go, observes status and result
   modport master (
      output go, multiplicand, multiplier,
      input  busy, done, product
   );

   // Multiplier side: consumes operands and go, reports status and result
   modport slave (
      input  go, multiplicand, multiplier,
      output busy, done, product
   );

endinterface

// File: rtl/multiplication32.sv
// rtl/multiplication32.sv - radix-2 LSB-first shift-add unsigned multiplier, one bit per clock
module multiplication32
   import energy_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   multiplication32_if.slave    bus
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_t                r_state;
   state_t                w_state_next;
   logic [2*WIDTH-1:0]    r_acc;
   logic [2*WIDTH-1:0]    r_mcand;
   logic [WIDTH-1:0]      r_mplier;
   logic [CNT_W-1:0]      r_cnt;
   logic [2*WIDTH-1:0]    r_product;
   logic                  r_done;

   logic [2*WIDTH-1:0]    w_addend;
   logic [2*WIDTH-1:0]    w_sum;
   logic                  w_last;

   // The full-width sum can never overflow: A*B < 2^(2*WIDTH)
   assign w_addend = r_mplier[0] ? r_mcand : '0;
   assign w_sum    = r_acc + w_addend;
   assign w_last   = (r_cnt == CNT_LAST);

   // State register and datapath; reset abandons any operation in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_acc     <= '0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_cnt     <= '0;
         r_product <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         case (r_state)
            S_IDLE: begin
               if (bus.go) begin
                  r_mcand  <= {{WIDTH{1'b0}}, bus.multiplicand};
                  r_mplier <= bus.multiplier;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_done   <= 1'b0;
               end
            end
            S_RUN: begin
               r_acc    <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
               // Only the completed sum is published, never a partial product
               if (w_last) begin
                  r_product <= w_sum;
                  r_done    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Next-state: go starts a run, the terminal count returns to idle
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.go) w_state_next = S_RUN;
         S_RUN:   if (w_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Outputs: busy decoded from the registered state, result and done are registers
   always_comb begin
      bus.busy    = (r_state == S_RUN);
      bus.done    = r_done;
      bus.product = r_product;
   end

endmodule

// File: tb/tb_multiplication32.sv
// tb/tb_multiplication32.sv - self-checking bench for the sequential shift-add multiplier
module tb_multiplication32;

   localparam int WIDTH = 32;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   multiplication32_if #(.WIDTH(WIDTH)) bus ();

   multiplication32 #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         tick();
         cyc++;
      end
   endtask

   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output int cyc, output int nbusy);
      bus.go           = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      tick();
      bus.go = 1'b0;
      cyc    = 0;
      nbusy  = 0;
      while (bus.done !== 1'b1 && cyc < 100) begin
         if (bus.busy === 1'b1) nbusy++;
         tick();
         cyc++;
      end
      p = bus.product;
   endtask

   initial begin
      vec_t        vecs [6];
      logic [63:0] p;
      logic [63:0] exp;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] expq [$];
      int          cyc;
      int          nbusy;

      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{32'd12345,      32'd6789,       64'd83810205};
      vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
      vecs[2] = '{32'h0000_0001,  32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF};
      vecs[3] = '{32'h0000_0000,  32'hDEAD_BEEF,  64'h0};
      vecs[4] = '{32'hFFFF_FFFF,  32'h0000_0002,  64'h0000_0001_FFFF_FFFE};
      vecs[5] = '{32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};

      rst              = 1'b1;
      bus.go           = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      repeat (2) tick();
      check("reset_product", bus.product, 64'h0);
      check("reset_done",    {63'h0, bus.done}, 64'h0);
      check("reset_busy",    {63'h0, bus.busy}, 64'h0);
      rst = 1'b0;
      tick();

      // Table-driven single operations
      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, p, cyc, nbusy);
         check($sformatf("vec%0d_product", i), p, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd32);
         check($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'd32);
         check($sformatf("vec%0d_busy_at_done", i), {63'h0, bus.busy}, 64'h0);
         tick();
      end

      // Mid-run go with new operands is ignored
      bus.go = 1'b1; bus.multiplicand = 32'd7; bus.multiplier = 32'd9;
      tick();
      bus.go = 1'b0;
      repeat (9) tick();
      bus.go = 1'b1; bus.multiplicand = 32'd3; bus.multiplier = 32'd3;
      tick();
      bus.go = 1'b0;
      check("midrun_busy", {63'h0, bus.busy}, 64'h1);
      wait_done(cyc);
      check("midrun_latency", 64'(cyc), 64'd22);
      check("midrun_product", bus.product, 64'd63);

      // Holding go while done is high restarts, done drops one cycle later
      bus.go = 1'b1;
      tick();
      check("restart_done_drop", {63'h0, bus.done}, 64'h0);
      check("restart_busy",      {63'h0, bus.busy}, 64'h1);
      check("restart_product_hold", bus.product, 64'd63);
      wait_done(cyc);
      bus.go = 1'b0;
      check("restart_latency", 64'(cyc), 64'd32);
      check("restart_product", bus.product, 64'd9);
      tick();

      // Asynchronous reset in the middle of a run
      bus.go = 1'b1; bus.multiplicand = 32'hFFFF; bus.multiplier = 32'hFFFF;
      tick();
      bus.go = 1'b0;
      repeat (14) tick();
      #2 rst = 1'b1;
      #1;
      check("async_rst_product", bus.product, 64'h0);
      check("async_rst_done",    {63'h0, bus.done}, 64'h0);
      check("async_rst_busy",    {63'h0, bus.busy}, 64'h0);
      repeat (2) tick();
      rst = 1'b0;
      repeat (40) tick();
      check("post_rst_product", bus.product, 64'h0);
      check("post_rst_done",    {63'h0, bus.done}, 64'h0);
      check("post_rst_busy",    {63'h0, bus.busy}, 64'h0);

      // Randomised back-to-back operations with go held high
      bus.go = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 97 == 0) a = 32'hFFFF_FFFF;
         if (i % 89 == 0) b = 32'h0;
         bus.multiplicand = a;
         bus.multiplier   = b;
         expq.push_back(64'(a) * 64'(b));
         tick();
         if (i == 999) bus.go = 1'b0;
         bus.multiplicand = $urandom;
         bus.multiplier   = $urandom;
         check("rand_done_clear", {63'h0, bus.done}, 64'h0);
         wait_done(cyc);
         check("rand_period", 64'(cyc), 64'd32);
         exp = expq.pop_front();
         check("rand_product", bus.product, exp);
      end
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
